alarm_clock_tick_sequencer: RTL and testbench
=============================================

// Module: alarm_clock_tick_sequencer
// PURPOSE
//  Avalon-MM master that programs and services the 1 Hz interval-timer slave
//  (16-bit register map). After reset it writes the period and starts the
//  timer in continuous, IRQ-enabled mode. On each timer IRQ it clears the
//  timeout, advances an hh:mm:ss time-of-day counter and raises an alarm pulse
//  on an hh:mm match. It sits between the timer and the alarm/jukebox logic.
// PARAMETERS
//  PERIOD      32'd49_999_999  timer load value (clock cycles per tick minus 1)
// PORTS
//  clk             in   1   system clock
//  reset           in   1   asynchronous, active-high reset
//  tmr_address     out  3   timer register select
//  tmr_chipselect  out  1   timer select
//  tmr_write_n     out  1   timer write strobe, active-low
//  tmr_writedata   out  16  timer write data
//  tmr_irq         in   1   timer interrupt (level)
//  reprogram       in   1   1-cycle pulse: re-run timer init sequence
//  set_valid       in   1   1-cycle pulse: load set_hh/mm/ss
//  set_hh          in   5   hours to load, 0..23
//  set_mm          in   6   minutes to load, 0..59
//  set_ss          in   6   seconds to load, 0..59
//  alarm_en        in   1   alarm compare enable
//  alarm_hh        in   5   alarm hours
//  alarm_mm        in   6   alarm minutes
//  hh,mm,ss        out  5/6/6  current time, registered
//  sec_pulse       out  1   1 cycle per serviced tick
//  alarm_pulse     out  1   1 cycle on alarm match
//  running         out  1   high once the timer has been started
// BEHAVIOUR
//  Reset: all outputs 0; tmr_write_n=1; tmr_chipselect=0; FSM=INIT_PL.
//  Bus: the slave has no waitrequest, so every write completes in the cycle
//   it is driven (chipselect=1, write_n=0). The master never reads.
//   Outside write states, chipselect=0 and write_n=1.
//  FSM, one cycle per state except IDLE:
//   INIT_PL: addr 2, data PERIOD[15:0] -> INIT_PH.
//   INIT_PH: addr 3, data PERIOD[31:16] -> INIT_CTL.
//   INIT_CTL: addr 1, data 16'h0007 (START|CONT|ITO); running<=1 -> GUARD.
//    The period writes must precede the control write, because a period
//    write stops the timer.
//   IDLE: wait for tmr_irq=1 -> CLR. A reprogram pulse -> INIT_PL
//    (running<=0); reprogram has priority over irq.
//   CLR: addr 0, data 0 (clears timeout); advance time; sec_pulse=1 -> GUARD.
//   GUARD: 1 dead cycle, because irq drops one cycle after the clear -> IDLE.
//   A reprogram arriving outside IDLE is latched and taken on the next IDLE.
//  Time advance: ss+1. At 59, ss wraps to 0 and carries into mm; at 59, mm
//   wraps to 0 and carries into hh; at 23, hh wraps to 0.
//   So 23:59:59 -> 00:00:00.
//  alarm_pulse: registered, asserted the cycle after CLR when the new ss==0,
//   {hh,mm}=={alarm_hh,alarm_mm} and alarm_en=1.
//  set_valid: loads the time on the next edge. If it coincides with CLR,
//   the set wins and that tick is dropped (no sec_pulse, no alarm).
//   Loading a time equal to the alarm does not fire the alarm.
//   Out-of-range set values are clamped to the field maximum (23/59/59).
//  Reset mid-sequence: the FSM restarts at INIT_PL and the time is zeroed.
//   The timer is re-initialised whatever state it was left in.
// TESTING
//  T1 reset release -> 3 writes: (2,PERIOD[15:0]), (3,PERIOD[31:16]),
//   (1,0x0007) on consecutive cycles; running=1.
//  T2 irq held until the clear -> exactly one (0,0x0000) write, one
//   sec_pulse, ss 0->1; no second write after the GUARD cycle.
//  T3 set 23:59:59, one irq -> 00:00:00. Set 10:59:59, one irq -> 11:00:00.
//  T4 alarm 07:30 en, set 07:29:59, irq -> alarm_pulse 1 cycle at 07:30:00.
//   Same with alarm_en=0 -> no pulse. Set 07:30:00 directly -> no pulse.
//  T5 set_valid in the CLR cycle -> time = set value, no sec_pulse.
//  T6 reprogram during GUARD -> init writes start after the next IDLE.
//   Reset asserted in INIT_PH -> sequence restarts at INIT_PL.

Source files
------------

// File: rtl/alarm_clock_tick_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_clock_tick_sequencer
//
// Avalon-MM master for a 16-bit interval-timer slave. After reset it loads the
// timer period and starts the timer in continuous mode with the IRQ enabled.
// Each timer IRQ is serviced by clearing the timeout. The service also advances
// an hh:mm:ss time-of-day counter and can raise a one-cycle alarm pulse when
// hh:mm matches the alarm setting.
//
// Ports
//   clk, reset                  system clock, asynchronous active-high reset
//   tmr_address/chipselect/
//   tmr_write_n/tmr_writedata   timer bus (write-only, no waitrequest)
//   tmr_irq                     timer interrupt, level
//   reprogram                   pulse: re-run the timer init sequence
//   set_valid, set_hh/mm/ss     pulse + value: load the time of day
//   alarm_en, alarm_hh/mm       alarm compare setting
//   hh, mm, ss                  current time (registered)
//   sec_pulse                   one cycle per serviced tick
//   alarm_pulse                 one cycle on alarm match
//   running                     timer has been started
// -----------------------------------------------------------------------------
module alarm_clock_tick_sequencer #(
   parameter logic [31:0] PERIOD = 32'd49_999_999
) (
   input  logic        clk,
   input  logic        reset,
   output logic [2:0]  tmr_address,
   output logic        tmr_chipselect,
   output logic        tmr_write_n,
   output logic [15:0] tmr_writedata,
   input  logic        tmr_irq,
   input  logic        reprogram,
   input  logic        set_valid,
   input  logic [4:0]  set_hh,
   input  logic [5:0]  set_mm,
   input  logic [5:0]  set_ss,
   input  logic        alarm_en,
   input  logic [4:0]  alarm_hh,
   input  logic [5:0]  alarm_mm,
   output logic [4:0]  hh,
   output logic [5:0]  mm,
   output logic [5:0]  ss,
   output logic        sec_pulse,
   output logic        alarm_pulse,
   output logic        running
);

   typedef enum logic [2:0] {
      INIT_PL  = 3'd0,
      INIT_PH  = 3'd1,
      INIT_CTL = 3'd2,
      IDLE     = 3'd3,
      CLR      = 3'd4,
      GUARD    = 3'd5
   } state_t;

   state_t      state_r;
   state_t      next_state_s;

   // Bus outputs are registered from the next-state decode so the write is
   // visible in exactly the cycle its state is current. The very first cycle
   // after reset has nothing registered yet, so INIT_PL is held one extra
   // cycle until primed_r is set.
   logic        primed_r;
   logic        reprog_pend_r;
   logic        take_reprog_s;

   logic        bus_cs_s;
   logic [2:0]  bus_addr_s;
   logic [15:0] bus_data_s;
   logic        bus_cs_r;
   logic        bus_write_n_r;
   logic [2:0]  bus_addr_r;
   logic [15:0] bus_data_r;

   logic [4:0]  hh_r;
   logic [5:0]  mm_r;
   logic [5:0]  ss_r;
   logic [4:0]  adv_hh_s;
   logic [5:0]  adv_mm_s;
   logic [5:0]  adv_ss_s;
   logic        sec_pulse_r;
   logic        alarm_pulse_r;
   logic        running_r;
   logic        tick_s;
   logic        alarm_hit_s;

   // Clamp an hours value to 0..23.
   function automatic logic [4:0] clamp_hours(input logic [4:0] v);
      if (v > 5'd23) begin
         clamp_hours = 5'd23;
      end else begin
         clamp_hours = v;
      end
   endfunction

   // Clamp a minutes/seconds value to 0..59.
   function automatic logic [5:0] clamp_sixty(input logic [5:0] v);
      if (v > 6'd59) begin
         clamp_sixty = 6'd59;
      end else begin
         clamp_sixty = v;
      end
   endfunction

   // A reprogram request is taken only from IDLE, either live or latched earlier.
   assign take_reprog_s = (state_r == IDLE) && (reprogram || reprog_pend_r);

   // A tick is serviced in CLR unless a time load in the same cycle overrides it.
   assign tick_s = (state_r == CLR) && !set_valid;

   assign alarm_hit_s = alarm_en && (adv_ss_s == 6'd0) &&
                        (adv_hh_s == alarm_hh) && (adv_mm_s == alarm_mm);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= INIT_PL;
         primed_r <= 1'b0;
      end else begin
         state_r  <= next_state_s;
         primed_r <= 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         INIT_PL: begin
            if (primed_r) begin
               next_state_s = INIT_PH;
            end else begin
               next_state_s = INIT_PL;
            end
         end
         INIT_PH:  next_state_s = INIT_CTL;
         INIT_CTL: next_state_s = GUARD;
         IDLE: begin
            if (take_reprog_s) begin
               next_state_s = INIT_PL;
            end else if (tmr_irq) begin
               next_state_s = CLR;
            end else begin
               next_state_s = IDLE;
            end
         end
         CLR:      next_state_s = GUARD;
         GUARD:    next_state_s = IDLE;
         default:  next_state_s = INIT_PL;
      endcase
   end

   // Output decode: bus write for the state about to become current.
   always_comb begin
      bus_cs_s   = 1'b0;
      bus_addr_s = 3'd0;
      bus_data_s = 16'h0000;
      case (next_state_s)
         INIT_PL: begin
            bus_cs_s   = 1'b1;
            bus_addr_s = 3'd2;
            bus_data_s = PERIOD[15:0];
         end
         INIT_PH: begin
            bus_cs_s   = 1'b1;
            bus_addr_s = 3'd3;
            bus_data_s = PERIOD[31:16];
         end
         INIT_CTL: begin
            // START | CONT | ITO
            bus_cs_s   = 1'b1;
            bus_addr_s = 3'd1;
            bus_data_s = 16'h0007;
         end
         CLR: begin
            bus_cs_s   = 1'b1;
            bus_addr_s = 3'd0;
            bus_data_s = 16'h0000;
         end
         default: begin
            bus_cs_s   = 1'b0;
            bus_addr_s = 3'd0;
            bus_data_s = 16'h0000;
         end
      endcase
   end

   // Bus output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus_cs_r      <= 1'b0;
         bus_write_n_r <= 1'b1;
         bus_addr_r    <= 3'd0;
         bus_data_r    <= 16'h0000;
      end else begin
         bus_cs_r      <= bus_cs_s;
         bus_write_n_r <= ~bus_cs_s;
         bus_addr_r    <= bus_addr_s;
         bus_data_r    <= bus_data_s;
      end
   end

   // Reprogram latch and running flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reprog_pend_r <= 1'b0;
         running_r     <= 1'b0;
      end else begin
         if (take_reprog_s) begin
            reprog_pend_r <= 1'b0;
         end else if (reprogram) begin
            reprog_pend_r <= 1'b1;
         end else begin
            reprog_pend_r <= reprog_pend_r;
         end

         if (state_r == INIT_CTL) begin
            running_r <= 1'b1;
         end else if (take_reprog_s) begin
            running_r <= 1'b0;
         end else begin
            running_r <= running_r;
         end
      end
   end

   // Time-of-day successor with ss -> mm -> hh carries.
   always_comb begin
      adv_ss_s = ss_r;
      adv_mm_s = mm_r;
      adv_hh_s = hh_r;
      if (ss_r >= 6'd59) begin
         adv_ss_s = 6'd0;
         if (mm_r >= 6'd59) begin
            adv_mm_s = 6'd0;
            if (hh_r >= 5'd23) begin
               adv_hh_s = 5'd0;
            end else begin
               adv_hh_s = hh_r + 5'd1;
            end
         end else begin
            adv_mm_s = mm_r + 6'd1;
         end
      end else begin
         adv_ss_s = ss_r + 6'd1;
      end
   end

   // Time-of-day counter and tick/alarm pulses; a time load beats a tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hh_r          <= 5'd0;
         mm_r          <= 6'd0;
         ss_r          <= 6'd0;
         sec_pulse_r   <= 1'b0;
         alarm_pulse_r <= 1'b0;
      end else begin
         if (set_valid) begin
            hh_r <= clamp_hours(set_hh);
            mm_r <= clamp_sixty(set_mm);
            ss_r <= clamp_sixty(set_ss);
         end else if (state_r == CLR) begin
            hh_r <= adv_hh_s;
            mm_r <= adv_mm_s;
            ss_r <= adv_ss_s;
         end else begin
            hh_r <= hh_r;
            mm_r <= mm_r;
            ss_r <= ss_r;
         end
         sec_pulse_r   <= tick_s;
         alarm_pulse_r <= tick_s && alarm_hit_s;
      end
   end

   assign tmr_address    = bus_addr_r;
   assign tmr_chipselect = bus_cs_r;
   assign tmr_write_n    = bus_write_n_r;
   assign tmr_writedata  = bus_data_r;
   assign hh             = hh_r;
   assign mm             = mm_r;
   assign ss             = ss_r;
   assign sec_pulse      = sec_pulse_r;
   assign alarm_pulse    = alarm_pulse_r;
   assign running        = running_r;

endmodule

// File: tb/tb_alarm_clock_tick_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for alarm_clock_tick_sequencer. Time of day is modelled
// as seconds-since-midnight; bus writes and pulses are logged by a monitor.
// -----------------------------------------------------------------------------
module tb_alarm_clock_tick_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  tmr_address;
   logic        tmr_chipselect;
   logic        tmr_write_n;
   logic [15:0] tmr_writedata;
   logic        tmr_irq = 1'b0;
   logic        reprogram = 1'b0;
   logic        set_valid = 1'b0;
   logic [4:0]  set_hh = 5'd0;
   logic [5:0]  set_mm = 6'd0;
   logic [5:0]  set_ss = 6'd0;
   logic        alarm_en = 1'b0;
   logic [4:0]  alarm_hh = 5'd0;
   logic [5:0]  alarm_mm = 6'd0;
   logic [4:0]  hh;
   logic [5:0]  mm;
   logic [5:0]  ss;
   logic        sec_pulse;
   logic        alarm_pulse;
   logic        running;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int sec_cnt = 0;
   int alarm_cnt = 0;
   int wa_q[$];
   int wd_q[$];
   int wc_q[$];
   int tod = 0;
   logic [31:0] period_c = 32'd49_999_999;

   alarm_clock_tick_sequencer dut (
      .clk(clk), .reset(reset),
      .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
      .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
      .tmr_irq(tmr_irq), .reprogram(reprogram),
      .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
      .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
      .hh(hh), .mm(mm), .ss(ss),
      .sec_pulse(sec_pulse), .alarm_pulse(alarm_pulse), .running(running)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Bus/pulse monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (tmr_chipselect === 1'b1 && tmr_write_n === 1'b0) begin
         wa_q.push_back(int'(tmr_address));
         wd_q.push_back(int'(tmr_writedata));
         wc_q.push_back(cyc);
      end
      if (sec_pulse === 1'b1) sec_cnt <= sec_cnt + 1;
      if (alarm_pulse === 1'b1) alarm_cnt <= alarm_cnt + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_time(input string tag);
      chk($sformatf("%s_hh", tag), int'(hh), tod / 3600);
      chk($sformatf("%s_mm", tag), int'(mm), (tod / 60) % 60);
      chk($sformatf("%s_ss", tag), int'(ss), tod % 60);
   endtask

   task automatic check_init(input string tag, input int base);
      chk($sformatf("%s_count", tag), wa_q.size() - base, 3);
      if (wa_q.size() >= base + 3) begin
         chk($sformatf("%s_a0", tag), wa_q[base], 2);
         chk($sformatf("%s_d0", tag), wd_q[base], int'(period_c[15:0]));
         chk($sformatf("%s_a1", tag), wa_q[base+1], 3);
         chk($sformatf("%s_d1", tag), wd_q[base+1], int'(period_c[31:16]));
         chk($sformatf("%s_a2", tag), wa_q[base+2], 1);
         chk($sformatf("%s_d2", tag), wd_q[base+2], 7);
         chk($sformatf("%s_gap", tag), wc_q[base+2] - wc_q[base], 2);
      end
   endtask

   // Reference: one second elapses; returns whether the alarm should fire.
   task automatic model_tick(output int exp_alarm);
      tod = (tod + 1) % 86400;
      exp_alarm = (alarm_en && (tod % 60 == 0) && (tod / 3600 == int'(alarm_hh)) &&
                   ((tod / 60) % 60 == int'(alarm_mm))) ? 1 : 0;
   endtask

   task automatic set_time(input string tag, input int h, input int m, input int s);
      int s0, a0;
      s0 = sec_cnt;
      a0 = alarm_cnt;
      @(negedge clk);
      set_hh = h[4:0];
      set_mm = m[5:0];
      set_ss = s[5:0];
      set_valid = 1'b1;
      @(negedge clk);
      set_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      tod = ((h > 23) ? 23 : h) * 3600 + ((m > 59) ? 59 : m) * 60 + ((s > 59) ? 59 : s);
      check_time(tag);
      chk($sformatf("%s_nosec", tag), sec_cnt - s0, 0);
      chk($sformatf("%s_noalarm", tag), alarm_cnt - a0, 0);
   endtask

   // Timer model: irq held until the clear write, dropped one cycle later.
   task automatic do_tick(input string tag);
      int n0, s0, a0, k, ea;
      n0 = wa_q.size();
      s0 = sec_cnt;
      a0 = alarm_cnt;
      @(negedge clk);
      tmr_irq = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         #1;
         k++;
      end while (wa_q.size() == n0 && k < 20);
      chk($sformatf("%s_clr_seen", tag), (wa_q.size() > n0) ? 1 : 0, 1);
      @(posedge clk);
      @(posedge clk);
      #1 tmr_irq = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      model_tick(ea);
      chk($sformatf("%s_writes", tag), wa_q.size() - n0, 1);
      if (wa_q.size() > n0) begin
         chk($sformatf("%s_clr_addr", tag), wa_q[n0], 0);
         chk($sformatf("%s_clr_data", tag), wd_q[n0], 0);
      end
      chk($sformatf("%s_sec", tag), sec_cnt - s0, 1);
      chk($sformatf("%s_alarm", tag), alarm_cnt - a0, ea);
      check_time(tag);
   endtask

   initial begin
      int n0, n1, s0, a0, op, nt;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_cs", int'(tmr_chipselect), 0);
      chk("rst_wn", int'(tmr_write_n), 1);
      chk("rst_running", int'(running), 0);
      chk("rst_sec", int'(sec_pulse), 0);
      chk("rst_alarm", int'(alarm_pulse), 0);
      check_time("rst");

      // T1: init writes after reset release
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      check_init("t1", 0);
      chk("t1_running", int'(running), 1);
      chk("t1_idle_cs", int'(tmr_chipselect), 0);

      // T2: single tick
      do_tick("t2");

      // T3: rollovers
      set_time("t3_set_a", 23, 59, 59);
      do_tick("t3_wrap_day");
      set_time("t3_set_b", 10, 59, 59);
      do_tick("t3_wrap_hr");

      // T4: alarm
      alarm_hh = 5'd7;
      alarm_mm = 6'd30;
      alarm_en = 1'b1;
      set_time("t4_set", 7, 29, 59);
      do_tick("t4_fire");
      alarm_en = 1'b0;
      set_time("t4_set_off", 7, 29, 59);
      do_tick("t4_off");
      alarm_en = 1'b1;
      set_time("t4_direct", 7, 30, 0);

      // Clamp of out-of-range load
      set_time("clamp", 31, 63, 60);

      // T5: set_valid in the CLR cycle
      n0 = wa_q.size();
      s0 = sec_cnt;
      @(negedge clk);
      tmr_irq = 1'b1;
      @(negedge clk);
      set_hh = 5'd12;
      set_mm = 6'd34;
      set_ss = 6'd56;
      set_valid = 1'b1;
      @(negedge clk);
      set_valid = 1'b0;
      tmr_irq = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      tod = 12 * 3600 + 34 * 60 + 56;
      chk("t5_writes", wa_q.size() - n0, 1);
      chk("t5_nosec", sec_cnt - s0, 0);
      check_time("t5");

      // T6: reprogram during GUARD
      n0 = wa_q.size();
      s0 = sec_cnt;
      @(negedge clk);
      tmr_irq = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reprogram = 1'b1;
      tmr_irq = 1'b0;
      @(negedge clk);
      reprogram = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("t6_running_low", int'(running), 0);
      repeat (6) @(negedge clk);
      #1;
      model_tick(op);
      chk("t6_total", wa_q.size() - n0, 4);
      if (wa_q.size() >= n0 + 4) begin
         chk("t6_clr_addr", wa_q[n0], 0);
         chk("t6_gap", wc_q[n0+1] - wc_q[n0], 3);
      end
      check_init("t6_init", n0 + 1);
      chk("t6_sec", sec_cnt - s0, 1);
      chk("t6_running", int'(running), 1);
      check_time("t6");

      // T6b: reset asserted in INIT_PH
      set_time("t6b_pre", 5, 6, 7);
      n0 = wa_q.size();
      @(negedge clk);
      reprogram = 1'b1;
      @(negedge clk);
      reprogram = 1'b0;
      @(negedge clk);
      #1 reset = 1'b1;
      chk("t6b_partial", wa_q.size() - n0, 2);
      if (wa_q.size() >= n0 + 2) begin
         chk("t6b_pl", wa_q[n0], 2);
         chk("t6b_ph", wa_q[n0+1], 3);
      end
      #1;
      chk("t6b_rst_cs", int'(tmr_chipselect), 0);
      tod = 0;
      check_time("t6b_rst");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      n1 = wa_q.size();
      repeat (8) @(negedge clk);
      #1;
      check_init("t6b_init", n1);
      chk("t6b_running", int'(running), 1);

      // Randomised sets/ticks against the seconds-of-day model
      for (int i = 0; i < 24; i++) begin
         op = $urandom_range(0, 2);
         if (op == 0) begin
            set_time($sformatf("r%0d_set", i), $urandom_range(0, 31),
                     $urandom_range(0, 63), $urandom_range(0, 63));
         end else begin
            if (op == 1) begin
               set_time($sformatf("r%0d_edge", i), $urandom_range(22, 31),
                        $urandom_range(58, 63), 59);
            end
            nt = (tod + 1) % 86400;
            alarm_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
               alarm_hh = 5'(nt / 3600);
               alarm_mm = 6'((nt / 60) % 60);
            end else begin
               alarm_hh = 5'($urandom_range(0, 23));
               alarm_mm = 6'($urandom_range(0, 59));
            end
            do_tick($sformatf("r%0d_tick", i));
         end
      end

      a0 = alarm_cnt;
      repeat (4) @(negedge clk);
      #1;
      chk("quiet_alarm", alarm_cnt - a0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
